bit_debouncer: RTL and testbench
================================

// Module: bit_debouncer
// PURPOSE
//   Downstream consumer of the single-bit D flip-flop stage: takes its 1-bit serial output,
//   resynchronises it and filters out glitches. Drives a debounced level plus one-cycle
//   rise/fall strobes for the control logic that follows. Optionally counts accepted edges.
// PARAMETERS
//   SYNC_STAGES    2   number of synchroniser flops on in (legal >= 1)
//   STABLE_CYCLES  4   consecutive cycles a new level must persist before acceptance (legal >= 1)
//   CNT_W          8   width of event_cnt (legal >= 1; used only with BIT_DEBOUNCER_EVENT_CNT_EN)
// PORTS
//   clk        input   1      rising-edge clock, single clock domain
//   reset      input   1      asynchronous, active-low reset (0 = reset asserted)
//   in         input   1      raw bit from upstream DFF stage, may glitch
//   out        output  1      debounced level, registered
//   rise       output  1      one-cycle pulse, same edge out goes 0->1
//   fall       output  1      one-cycle pulse, same edge out goes 1->0
//   event_cnt  output  CNT_W  accepted transitions, modulo 2^CNT_W (macro-only port)
// BEHAVIOUR
//   - Reset (reset=0): asynchronous, takes effect without a clock edge.
//     - Sync chain = 0; out = 0; rise = 0; fall = 0; event_cnt = 0.
//     - Stability counter = 0; FSM = IDLE.
//   - Sync: in -> SYNC_STAGES flops; sync = last stage.
//   - All decisions use sync only; in is never used combinationally.
//   - FSM, two states:
//     - IDLE:  sync == out -> stay, cnt = 0.
//              sync != out, STABLE_CYCLES == 1 -> accept this edge (see below).
//              sync != out, otherwise -> cnt = 1, go to COUNT.
//     - COUNT: sync == out -> glitch rejected; cnt = 0, go to IDLE, no strobes.
//              sync != out, cnt == STABLE_CYCLES-1 -> accept.
//              sync != out, otherwise -> cnt++.
//     - accept: out <= sync; rise <= sync; fall <= ~sync; cnt = 0; go to IDLE.
//   - Counter width: stability counter is $clog2(STABLE_CYCLES+1) bits. It never reaches
//     STABLE_CYCLES and never wraps.
//   - rise/fall: registered; high for exactly one cycle per acceptance, never simultaneously.
//     Zero on every cycle without an acceptance.
//   - Latency: a step on in set up before edge 0 and held changes out on edge
//     SYNC_STAGES+STABLE_CYCLES-1 (edge 5 with defaults). Out is valid after that edge.
//   - Minimum accepted pulse width on sync: STABLE_CYCLES cycles.
//   - Narrower pulses are fully suppressed (out, rise, fall unchanged).
//   - Back-to-back toggling faster than STABLE_CYCLES: out holds its last accepted level.
//   - Reset mid-count: progress discarded. If in=1 after release, the full latency is
//     needed again, then a rise strobe fires.
// CONFIGURATION
//   BIT_DEBOUNCER_EVENT_CNT_EN defined:
//     - event_cnt port exists.
//     - Increments by 1 on every acceptance (same edge as rise/fall).
//     - Wraps 2^CNT_W-1 -> 0.
//   BIT_DEBOUNCER_EVENT_CNT_EN undefined:
//     - event_cnt port and counter logic are absent.
//     - out/rise/fall behaviour is identical to the defined case.
// TESTING (defaults unless stated; edges counted from first edge after stimulus change)
//   1. reset=0 with in=1 -> out=0, rise=0, fall=0, event_cnt=0 with no clock running.
//      Then release, hold in=1 -> out=1 at edge 5, rise=1 for that one cycle only, event_cnt=1.
//   2. out=0, in=1 for 3 cycles then 0 -> out stays 0, rise never asserts, event_cnt unchanged.
//      Same with in=1 for exactly 4 cycles -> out=1, single rise pulse.
//   3. out=1, in=0 held 10 cycles -> fall=1 for one cycle at edge 5, out=0, rise=0 throughout,
//      event_cnt incremented by 1.
//   4. in toggling every 2 cycles for 40 cycles -> out, rise, fall constant (no acceptance).
//   5. CNT_W=2, macro on: 4 accepted transitions (in held 10 cycles each) -> event_cnt 1,2,3,0.
//   6. in=1 for 4 cycles, reset pulsed low between edges -> out, cnt and the sync chain clear
//      immediately. After release with in=1, rise occurs 6 edges later. Repeat the bench
//      with the macro undefined: the same out/rise/fall waveform is required.

Source files
------------

// File: rtl/bit_debouncer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | bit_debouncer_if : raw bit in, debounced level / edge strobes out                 |
// | Optional event_cnt member under BIT_DEBOUNCER_EVENT_CNT_EN.    Rev 1.0             |
// +-----------------------------------------------------------------------------------+
interface bit_debouncer_if
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
   #(parameter int CNT_W = 8)
`endif
   ;
   logic in;
   logic out;
   logic rise;
   logic fall;
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
   logic [CNT_W-1:0] event_cnt;

   modport master (output in, input out, input rise, input fall, input event_cnt);
   modport slave  (input in, output out, output rise, output fall, output event_cnt);
`else
   modport master (output in, input out, input rise, input fall);
   modport slave  (input in, output out, output rise, output fall);
`endif
endinterface
`default_nettype wire

// File: rtl/bit_debouncer.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | bit_debouncer : synchroniser + stability filter with one-cycle rise/fall strobes  |
// | BIT_DEBOUNCER_EVENT_CNT_EN adds the accepted-edge counter.     Rev 1.0             |
// +-----------------------------------------------------------------------------------+
module bit_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input wire logic       clk,
   input wire logic       reset,
   bit_debouncer_if.slave bus
);

   localparam int              CW       = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   generate
      if (SYNC_STAGES < 1 || STABLE_CYCLES < 1 || CNT_W < 1) begin : g_param_check
         $fatal(1, "bit_debouncer: SYNC_STAGES, STABLE_CYCLES and CNT_W must be >= 1");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync;

   generate
      if (SYNC_STAGES == 1) begin : g_sync_single
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) sync_chain <= '0;
            else        sync_chain <= bus.in;
         end
      end else begin : g_sync_multi
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) sync_chain <= '0;
            else        sync_chain <= {sync_chain[SYNC_STAGES-2:0], bus.in};
         end
      end
   endgenerate

   assign sync = sync_chain[SYNC_STAGES-1];

   state_t          state, state_nxt;
   logic [CW-1:0]   stable_cnt, stable_cnt_nxt;
   logic            out_level, out_level_nxt;
   logic            rise_pulse, rise_pulse_nxt;
   logic            fall_pulse, fall_pulse_nxt;
   logic            accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         stable_cnt <= '0;
         out_level  <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         stable_cnt <= stable_cnt_nxt;
         out_level  <= out_level_nxt;
         rise_pulse <= rise_pulse_nxt;
         fall_pulse <= fall_pulse_nxt;
      end
   end

   // A disagreement must persist STABLE_CYCLES consecutive samples; any agreement restarts.
   always_comb begin
      state_nxt      = state;
      stable_cnt_nxt = stable_cnt;
      out_level_nxt  = out_level;
      rise_pulse_nxt = 1'b0;
      fall_pulse_nxt = 1'b0;
      accept         = 1'b0;

      case (state)
         IDLE: begin
            if (sync == out_level) begin
               stable_cnt_nxt = '0;
            end else if (STABLE_CYCLES == 1) begin
               accept = 1'b1;
            end else begin
               stable_cnt_nxt = CW'(1);
               state_nxt      = COUNT;
            end
         end
         COUNT: begin
            if (sync == out_level) begin
               stable_cnt_nxt = '0;
               state_nxt      = IDLE;
            end else if (stable_cnt == CNT_LAST) begin
               accept = 1'b1;
            end else begin
               stable_cnt_nxt = stable_cnt + CW'(1);
            end
         end
         default: begin
            stable_cnt_nxt = '0;
            state_nxt      = IDLE;
         end
      endcase

      if (accept) begin
         out_level_nxt  = sync;
         rise_pulse_nxt = sync;
         fall_pulse_nxt = ~sync;
         stable_cnt_nxt = '0;
         state_nxt      = IDLE;
      end
   end

   assign bus.out  = out_level;
   assign bus.rise = rise_pulse;
   assign bus.fall = fall_pulse;

`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
   logic [CNT_W-1:0] events;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      events <= '0;
      else if (accept) events <= events + CNT_W'(1);
   end

   assign bus.event_cnt = events;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_debouncer.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | tb_bit_debouncer : vector table, corner sequences and random run vs. run-length    |
// | reference model. Honours BIT_DEBOUNCER_EVENT_CNT_EN.           Rev 1.0             |
// +-----------------------------------------------------------------------------------+
module tb_bit_debouncer;

   localparam int SYNC_STAGES   = 2;
   localparam int STABLE_CYCLES = 4;
   localparam int CNT_W         = 2;

   logic clk;
   logic clk_run;
   logic reset;

`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
   bit_debouncer_if #(.CNT_W(CNT_W)) bus ();
`else
   bit_debouncer_if bus ();
`endif

   bit_debouncer #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 if (clk_run) clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference: in is seen SYNC_STAGES edges late; count consecutive disagreeing samples.
   logic m_pipe [SYNC_STAGES];
   logic m_out, m_rise, m_fall;
   int   m_run;
   int   m_evt;

   int   seg_rises, seg_falls, seg_idx, first_fall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 1'b0;
      m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_evt = 0;
   endtask

   task automatic model_step(input logic v);
      logic seen;
      seen = m_pipe[SYNC_STAGES-1];
      for (int i = SYNC_STAGES-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = v;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (seen != m_out) begin
         m_run++;
         if (m_run == STABLE_CYCLES) begin
            m_out  = seen;
            m_rise = seen;
            m_fall = ~seen;
            m_run  = 0;
            m_evt  = (m_evt + 1) % (1 << CNT_W);
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic check_outputs();
      chk("out_vs_model",  32'(bus.out),  32'(m_out));
      chk("rise_vs_model", 32'(bus.rise), 32'(m_rise));
      chk("fall_vs_model", 32'(bus.fall), 32'(m_fall));
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
      chk("evt_vs_model",  32'(bus.event_cnt), 32'(m_evt));
`endif
   endtask

   task automatic cycle(input logic v);
      bus.in = v;
      @(posedge clk);
      model_step(v);
      @(negedge clk);
      check_outputs();
      if (bus.rise === 1'b1) seg_rises++;
      if (bus.fall === 1'b1) begin
         seg_falls++;
         if (first_fall < 0) first_fall = seg_idx;
      end
      seg_idx++;
   endtask

   task automatic seg_clear();
      seg_rises = 0; seg_falls = 0; seg_idx = 0; first_fall = -1;
   endtask

   task automatic run_seg(input logic v, input int n);
      for (int i = 0; i < n; i++) cycle(v);
   endtask

   // Called at a falling edge: pulse reset low and release it before the next rising edge.
   task automatic pulse_reset();
      reset = 1'b0;
      model_reset();
      #2;
      reset = 1'b1;
   endtask

   typedef struct {
      logic lvl_a;
      int   len_a;
      logic lvl_b;
      int   len_b;
      logic exp_out;
      int   exp_rises;
      int   exp_falls;
   } vec_t;

   vec_t vecs [8];

`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
   int   evt_exp [4];
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1,  3, 1'b0, 10, 1'b0, 0, 0};
      vecs[1] = '{1'b1,  4, 1'b0, 10, 1'b0, 1, 1};
      vecs[2] = '{1'b1, 10, 1'b1,  2, 1'b1, 1, 0};
      vecs[3] = '{1'b0,  3, 1'b1, 10, 1'b1, 0, 0};
      vecs[4] = '{1'b0,  4, 1'b1, 10, 1'b1, 1, 1};
      vecs[5] = '{1'b0, 12, 1'b0,  1, 1'b0, 0, 1};
      vecs[6] = '{1'b0,  2, 1'b1, 10, 1'b1, 1, 0};
      vecs[7] = '{1'b1,  5, 1'b0,  9, 1'b0, 0, 1};
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
      evt_exp[0] = 1; evt_exp[1] = 2; evt_exp[2] = 3; evt_exp[3] = 0;
`endif

      // Asynchronous reset with the clock stopped.
      clk = 1'b0; clk_run = 1'b0; reset = 1'b1; bus.in = 1'b1;
      #3 reset = 1'b0;
      model_reset();
      #10;
      chk("reset_out",  32'(bus.out),  32'd0);
      chk("reset_rise", 32'(bus.rise), 32'd0);
      chk("reset_fall", 32'(bus.fall), 32'd0);
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
      chk("reset_evt",  32'(bus.event_cnt), 32'd0);
`endif
      reset = 1'b1;
      clk_run = 1'b1;

      // Held step: out rises on edge index 5, strobe lasts one cycle.
      seg_clear();
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1);
         chk("lat_out",  32'(bus.out),  (k >= 5) ? 32'd1 : 32'd0);
         chk("lat_rise", 32'(bus.rise), (k == 5) ? 32'd1 : 32'd0);
      end
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
      chk("lat_evt", 32'(bus.event_cnt), 32'd1);
`endif

      // Held fall: single fall strobe at edge index 5, no rise.
      seg_clear();
      run_seg(1'b0, 10);
      chk("fall_count",  32'(seg_falls),  32'd1);
      chk("fall_edge",   32'(first_fall), 32'd5);
      chk("fall_norise", 32'(seg_rises),  32'd0);
      chk("fall_out",    32'(bus.out),    32'd0);
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
      chk("fall_evt", 32'(bus.event_cnt), 32'd2);
`endif

      // Toggling every two cycles is never accepted.
      seg_clear();
      for (int k = 0; k < 20; k++) run_seg(k[0] ? 1'b0 : 1'b1, 2);
      chk("toggle_out",   32'(bus.out),   32'd0);
      chk("toggle_rises", 32'(seg_rises), 32'd0);
      chk("toggle_falls", 32'(seg_falls), 32'd0);

      // Vector table, starting from a clean reset.
      run_seg(1'b0, 4);
      pulse_reset();
      for (int v = 0; v < 8; v++) begin
         seg_clear();
         run_seg(vecs[v].lvl_a, vecs[v].len_a);
         run_seg(vecs[v].lvl_b, vecs[v].len_b);
         chk($sformatf("vec%0d_out", v),   32'(bus.out),   32'(vecs[v].exp_out));
         chk($sformatf("vec%0d_rises", v), 32'(seg_rises), 32'(vecs[v].exp_rises));
         chk($sformatf("vec%0d_falls", v), 32'(seg_falls), 32'(vecs[v].exp_falls));
      end

      // Four accepted transitions from reset: counter wraps at 2^CNT_W.
      @(negedge clk);
      pulse_reset();
      for (int k = 0; k < 4; k++) begin
         run_seg(k[0] ? 1'b0 : 1'b1, 10);
         chk($sformatf("wrap%0d_out", k), 32'(bus.out), k[0] ? 32'd0 : 32'd1);
`ifdef BIT_DEBOUNCER_EVENT_CNT_EN
         chk($sformatf("wrap%0d_evt", k), 32'(bus.event_cnt), 32'(evt_exp[k]));
`endif
      end

      // Reset mid-count clears progress immediately; full latency is needed again.
      run_seg(1'b1, 4);
      reset = 1'b0;
      model_reset();
      #1;
      chk("midrst_out",  32'(bus.out),  32'd0);
      chk("midrst_rise", 32'(bus.rise), 32'd0);
      chk("midrst_fall", 32'(bus.fall), 32'd0);
      #1 reset = 1'b1;
      seg_clear();
      for (int k = 0; k < 8; k++) begin
         cycle(1'b1);
         chk("midrst_rise_edge", 32'(bus.rise), (k == 5) ? 32'd1 : 32'd0);
      end

      // Random run lengths around the acceptance threshold.
      for (int k = 0; k < 120; k++) begin
         run_seg(1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
